// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: hazard, branch and memory-stall
// arbitration, halt-drain FSM and a sticky memory-stall watchdog.
module pipeline_ctrl #(
  parameter int DRAIN_CYCLES   = 3,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] p0Addr_ID,
  input  logic [3:0] p1Addr_ID,
  input  logic       p0Used_ID,
  input  logic       p1Used_ID,
  input  logic [3:0] regAddr_ID_EX,
  input  logic       regWe_ID_EX,
  input  logic       memToReg_ID_EX,
  input  logic       branchTaken_EX,
  input  logic       hlt_ID,
  input  logic       imemRdy,
  input  logic       dmemReq_MEM,
  input  logic       dmemRdy,
  output logic       pcWe,
  output logic       we_IF_ID,
  output logic       we_ID_EX,
  output logic       we_EX_MEM,
  output logic       we_MEM_WB,
  output logic       flush_IF_ID,
  output logic       flush_ID_EX,
  output logic       halted,
  output logic       memTimeout,
  output logic [1:0] state
);

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_DRAIN  = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;

  logic [1:0] state_q, state_d;
  logic [7:0] drain_cnt_q, drain_cnt_d;
  logic [7:0] stall_cnt_q, stall_cnt_d;
  logic       halted_q, halted_d;
  logic       mem_timeout_q, mem_timeout_d;

  logic mem_stall;
  logic load_use;

  assign mem_stall = !imemRdy | (dmemReq_MEM & !dmemRdy);
  // r0 is hardwired zero, so a load targeting it never creates a dependency.
  assign load_use  = regWe_ID_EX & memToReg_ID_EX & (regAddr_ID_EX != 4'd0) &
                     ((p0Used_ID & (p0Addr_ID == regAddr_ID_EX)) |
                      (p1Used_ID & (p1Addr_ID == regAddr_ID_EX)));

  always_comb begin
    pcWe        = 1'b1;
    we_IF_ID    = 1'b1;
    we_ID_EX    = 1'b1;
    we_EX_MEM   = 1'b1;
    we_MEM_WB   = 1'b1;
    flush_IF_ID = 1'b0;
    flush_ID_EX = 1'b0;
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    case (state_q)
      ST_RUN: begin
        if (mem_stall) begin
          {pcWe, we_IF_ID, we_ID_EX, we_EX_MEM, we_MEM_WB} = 5'b0;
        end else if (branchTaken_EX) begin
          flush_IF_ID = 1'b1;
          flush_ID_EX = 1'b1;
        end else if (load_use) begin
          pcWe        = 1'b0;
          we_IF_ID    = 1'b0;
          flush_ID_EX = 1'b1;
        end else if (hlt_ID) begin
          pcWe        = 1'b0;
          flush_IF_ID = 1'b1;
          state_d     = ST_DRAIN;
          drain_cnt_d = 8'(DRAIN_CYCLES - 1);
        end
      end
      ST_DRAIN: begin
        // Only HLT and younger bubbles remain; let them walk out to WB.
        pcWe        = 1'b0;
        flush_IF_ID = 1'b1;
        if (mem_stall) begin
          {we_IF_ID, we_ID_EX, we_EX_MEM, we_MEM_WB} = 4'b0;
        end else if (drain_cnt_q == 8'd0) begin
          state_d = ST_HALTED;
        end else begin
          drain_cnt_d = drain_cnt_q - 8'd1;
        end
      end
      default: begin
        {pcWe, we_IF_ID, we_ID_EX, we_EX_MEM, we_MEM_WB} = 5'b0;
      end
    endcase
  end

  always_comb begin
    stall_cnt_d   = stall_cnt_q;
    mem_timeout_d = mem_timeout_q;
    if (state_q != ST_HALTED) begin
      if (mem_stall) begin
        if (stall_cnt_q != 8'hFF) stall_cnt_d = stall_cnt_q + 8'd1;
        if (stall_cnt_d == 8'(TIMEOUT_CYCLES)) mem_timeout_d = 1'b1;
      end else begin
        stall_cnt_d = 8'd0;
      end
    end
    halted_d = (state_d == ST_HALTED);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_RUN;
      drain_cnt_q   <= 8'd0;
      stall_cnt_q   <= 8'd0;
      halted_q      <= 1'b0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      drain_cnt_q   <= drain_cnt_d;
      stall_cnt_q   <= stall_cnt_d;
      halted_q      <= halted_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  assign state      = state_q;
  assign halted     = halted_q;
  assign memTimeout = mem_timeout_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: a behavioural model predicts every cycle's
// outputs into a queue and a negedge monitor compares them against the DUT.
module tb_pipeline_ctrl;

  localparam int DRAIN   = 3;
  localparam int TIMEOUT = 255;

  typedef struct packed {
    logic [3:0] a0;
    logic [3:0] a1;
    logic       u0;
    logic       u1;
    logic [3:0] rd;
    logic       rwe;
    logic       m2r;
    logic       br;
    logic       hlt;
    logic       imem;
    logic       dreq;
    logic       drdy;
  } in_t;

  typedef struct packed {
    logic [6:0] en;
    logic       halted;
    logic       mt;
    logic [1:0] st;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  in_t  cur;

  logic       pcWe, we_IF_ID, we_ID_EX, we_EX_MEM, we_MEM_WB;
  logic       flush_IF_ID, flush_ID_EX, halted, memTimeout;
  logic [1:0] state;

  always #5 clk = ~clk;

  pipeline_ctrl #(.DRAIN_CYCLES(DRAIN), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .p0Addr_ID(cur.a0), .p1Addr_ID(cur.a1),
    .p0Used_ID(cur.u0), .p1Used_ID(cur.u1),
    .regAddr_ID_EX(cur.rd), .regWe_ID_EX(cur.rwe), .memToReg_ID_EX(cur.m2r),
    .branchTaken_EX(cur.br), .hlt_ID(cur.hlt),
    .imemRdy(cur.imem), .dmemReq_MEM(cur.dreq), .dmemRdy(cur.drdy),
    .pcWe(pcWe), .we_IF_ID(we_IF_ID), .we_ID_EX(we_ID_EX),
    .we_EX_MEM(we_EX_MEM), .we_MEM_WB(we_MEM_WB),
    .flush_IF_ID(flush_IF_ID), .flush_ID_EX(flush_ID_EX),
    .halted(halted), .memTimeout(memTimeout), .state(state)
  );

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model: mode 0 running, 1 draining, 2 halted.
  int mode, drain_left, stall_run;
  bit timeout_flag;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("enables", {pcWe, we_IF_ID, we_ID_EX, we_EX_MEM, we_MEM_WB, flush_IF_ID, flush_ID_EX}, e.en);
      check("halted", halted, e.halted);
      check("memTimeout", memTimeout, e.mt);
      check("state", state, e.st);
    end
  end

  function automatic in_t idle();
    in_t v;
    v = '0;
    v.imem = 1'b1;
    v.drdy = 1'b1;
    return v;
  endfunction

  task automatic model_reset();
    mode = 0; drain_left = 0; stall_run = 0; timeout_flag = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cur = idle();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  // Apply one cycle of inputs, predict outputs, then advance the model over the edge.
  task automatic step(input in_t v);
    exp_t e;
    bit ms, lu;
    bit pc, wif, wid, wex, wmw, fif, fid;
    cur = v;
    ms = !v.imem || (v.dreq && !v.drdy);
    lu = v.rwe && v.m2r && v.rd != 0 &&
         ((v.u0 && v.a0 == v.rd) || (v.u1 && v.a1 == v.rd));
    {pc, wif, wid, wex, wmw, fif, fid} = 7'b1111100;
    if (mode == 0) begin
      if (ms)        {pc, wif, wid, wex, wmw} = 5'b0;
      else if (v.br) {fif, fid} = 2'b11;
      else if (lu)   begin pc = 0; wif = 0; fid = 1; end
      else if (v.hlt) begin pc = 0; fif = 1; end
    end else if (mode == 1) begin
      pc = 0; fif = 1;
      if (ms) {wif, wid, wex, wmw} = 4'b0;
    end else begin
      {pc, wif, wid, wex, wmw, fif, fid} = 7'b0;
    end
    e.en = {pc, wif, wid, wex, wmw, fif, fid};
    e.halted = (mode == 2);
    e.mt = timeout_flag;
    e.st = 2'(mode);
    exp_q.push_back(e);

    if (mode != 2) begin
      stall_run = ms ? ((stall_run < 255) ? stall_run + 1 : 255) : 0;
      if (stall_run >= TIMEOUT) timeout_flag = 1;
    end
    if (mode == 0 && !ms && !v.br && !lu && v.hlt) begin
      mode = 1;
      drain_left = DRAIN - 1;
    end else if (mode == 1 && !ms) begin
      if (drain_left == 0) mode = 2;
      else drain_left--;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL sim_timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

  initial begin
    in_t v;
    cur = idle();
    do_reset();
    repeat (2) step(idle());

    // Load r3 in EX, ID reads r3 on p1: one bubble then free flow.
    v = idle(); v.rd = 4'd3; v.rwe = 1; v.m2r = 1; v.a1 = 4'd3; v.u1 = 1;
    step(v);
    step(idle());
    v.rd = 4'd0; v.a1 = 4'd0; step(v);
    v.rd = 4'd3; v.a1 = 4'd3; v.u1 = 0; step(v);
    v.u0 = 1; v.a0 = 4'd3; step(v);

    // Branch squashes load-use and HLT.
    v = idle(); v.rd = 4'd5; v.rwe = 1; v.m2r = 1; v.a0 = 4'd5; v.u0 = 1;
    v.br = 1; v.hlt = 1;
    step(v);
    v.br = 0; step(v);   // load-use holds HLT back
    v.rwe = 0; step(v);  // HLT now enters drain
    repeat (6) step(idle());

    // Mid-drain data stall delays the halt.
    do_reset();
    v = idle(); v.hlt = 1; step(v);
    step(idle());
    v = idle(); v.dreq = 1; v.drdy = 0;
    repeat (5) step(v);
    repeat (6) step(idle());

    // Fetch stall long enough to trip the watchdog, then reset mid-stall.
    do_reset();
    v = idle(); v.imem = 0;
    repeat (TIMEOUT + 3) step(v);
    repeat (3) step(idle());
    repeat (4) step(v);
    do_reset();
    repeat (2) step(idle());

    // Randomized segments, reset between them.
    for (int seg = 0; seg < 6; seg++) begin
      do_reset();
      for (int c = 0; c < 300; c++) begin
        v.a0   = 4'($urandom_range(0, 3));
        v.a1   = 4'($urandom_range(0, 3));
        v.u0   = 1'($urandom_range(0, 1));
        v.u1   = 1'($urandom_range(0, 1));
        v.rd   = 4'($urandom_range(0, 3));
        v.rwe  = 1'($urandom_range(0, 1));
        v.m2r  = 1'($urandom_range(0, 1));
        v.br   = ($urandom_range(0, 7) == 0);
        v.hlt  = ($urandom_range(0, 15) == 0);
        v.imem = ($urandom_range(0, 7) != 0);
        v.dreq = 1'($urandom_range(0, 1));
        v.drdy = 1'($urandom_range(0, 1));
        step(v);
      end
    end

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain_queue: got %0d pending expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
